axi_lite_master_ctrl: RTL and testbench
=======================================

Name:
axi_lite_master_ctrl

Overview:
- Command-driven AXI-Lite master that sequences single read/write transactions into the AXI-Lite control slave (base 0x0000_1000).
- Replaces hand-driven bench stimulus and serves as the on-chip configuration master.
- Accepts one command at a time and drives the AW/W/B or AR/R channels with correct, independent handshakes.
- Returns one response pulse per command.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width (wstrb width = DATA_W/8).
- TIMEOUT_CYCLES, 256, response-wait limit (used only with the optional feature).

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_we_i  in  1  1=write, 0=read
- cmd_addr_i  in  ADDR_W  transaction address
- cmd_wdata_i  in  DATA_W  write data
- cmd_wstrb_i  in  DATA_W/8  write strobes
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_rdata_o  out  DATA_W  read data (0 for writes)
- rsp_resp_o  out  2  BRESP/RRESP of completed transaction
- axi_awvalid_o/axi_awready_i  out/in  1  write-address handshake
- axi_awaddr_o  out  ADDR_W  write address
- axi_wvalid_o/axi_wready_i  out/in  1  write-data handshake
- axi_wdata_o  out  DATA_W  write data
- axi_wstrb_o  out  DATA_W/8  write strobes
- axi_bvalid_i/axi_bready_o  in/out  1  write-response handshake
- axi_bresp_i  in  2  write response
- axi_arvalid_o/axi_arready_i  out/in  1  read-address handshake
- axi_araddr_o  out  ADDR_W  read address
- axi_rvalid_i/axi_rready_o  in/out  1  read-data handshake
- axi_rdata_i  in  DATA_W  read data
- axi_rresp_i  in  2  read response

Behaviour:
- Reset (rst_ni=0, asynchronous): FSM=IDLE; all *valid_o, *ready_o, and rsp_valid_o = 0; cmd_ready_o = 0 during reset; rsp_rdata_o, rsp_resp_o, and AXI address/data outputs = 0. Reset mid-transaction aborts immediately, with no response.
- IDLE: cmd_ready_o=1. On cmd_valid_i, latch addr/wdata/wstrb/we; go to WADDR if we=1, else RADDR.
- WADDR: awvalid_o and wvalid_o asserted from the cycle after acceptance.
  - aw_done/w_done flags latch each handshake independently.
  - A valid drops the cycle after its own handshake and never re-asserts within the command.
  - Both handshakes in the same cycle are legal.
  - When both are done, go to WRESP.
  - Address and data remain stable while their valid is high.
- WRESP: bready_o=1. On bvalid_i, capture bresp, set rsp_rdata_o=0, go to DONE.
- RADDR: arvalid_o=1 until arready_i, then go to RDATA.
- RDATA: rready_o=1. On rvalid_i, capture rdata/rresp, go to DONE.
- DONE: rsp_valid_o=1 for exactly one cycle, with no backpressure. rsp_rdata_o/rsp_resp_o hold until the next DONE. Return to IDLE; cmd_ready_o=1 the following cycle.
- Minimum latency with a zero-wait slave, acceptance to rsp_valid_o:
  - Write: 3 cycles (WADDR, WRESP, DONE).
  - Read: 3 cycles (RADDR, RDATA, DONE).
- Slave responses are passed through unchanged; 2'b10 (SLVERR, e.g. illegal address bit 31 set) is reported, not retried.
- Only one transaction is outstanding; reads and writes never overlap.

Optional Feature:
- Macro: AXI_MASTER_TIMEOUT_EN.
- Defined:
  - A counter runs in WRESP and RDATA and clears on state entry.
  - When it reaches TIMEOUT_CYCLES without bvalid_i/rvalid_i, the block emits a DONE pulse with rsp_resp_o=2'b11 and rsp_rdata_o=0, drops the ready, and returns to IDLE.
  - A late response is ignored because ready is low.
- Undefined: no counter; the block waits indefinitely.

Test Plan:
- Write 0x0000_100A data 0xFF, wstrb 0xF, zero-wait slave -> AW and W handshake same cycle; rsp_valid 3 cycles after acceptance; rsp_resp=00.
- Read 0x0000_100A after that write -> araddr=0x0000_100A; rsp_rdata=0x0000_00FF; rsp_resp=00.
- Write 0x8000_100A (illegal) -> rsp_resp=10; a following read of 0x0000_100A still returns 0xFF.
- Slave delays wready 4 cycles after awready -> awvalid drops after its handshake; wvalid holds 0xAA stable; single bready handshake; rsp_resp=00.
- rst_ni low during WRESP -> bready_o, rsp_valid_o, and cmd_ready_o go to 0 immediately; after release cmd_ready_o=1 and no response is emitted.
- With AXI_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never asserts rvalid -> rsp_valid after 8 RDATA cycles, rsp_resp=11, rsp_rdata=0.

Source files
------------

// File: rtl/axi_lite_master_ctrl_if.sv
// axi_lite_master_ctrl_if: single-beat AXI-Lite bus (AW/W/B/AR/R).
// master modport drives valids/payload and B/R readies.
interface axi_lite_master_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr,
        input  arready,
        input  rvalid, rdata, rresp,
        output rready
    );

    modport slave (
        input  awvalid, awaddr,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr,
        output arready,
        output rvalid, rdata, rresp,
        input  rready
    );
endinterface

// File: rtl/axi_lite_master_ctrl.sv
// axi_lite_master_ctrl: command-driven single-transaction AXI-Lite master.
// Optional response timeout enabled by defining AXI_MASTER_TIMEOUT_EN.
module axi_lite_master_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [DATA_W-1:0]   cmd_wdata_i,
    input  logic [DATA_W/8-1:0] cmd_wstrb_i,
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic [1:0]          rsp_resp_o,
    axi_lite_master_ctrl_if.master axi
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_DONE
    } state_t;

    state_t state_q;
    logic   aw_done_q;
    logic   w_done_q;
    logic   aw_hs;
    logic   w_hs;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q;
`endif

    assign aw_hs = axi.awvalid & axi.awready;
    assign w_hs  = axi.wvalid & axi.wready;

    // Command sequencer: every output is a register owned by this FSM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_resp_o  <= 2'b00;
            axi.awvalid <= 1'b0;
            axi.awaddr  <= '0;
            axi.wvalid  <= 1'b0;
            axi.wdata   <= '0;
            axi.wstrb   <= '0;
            axi.bready  <= 1'b0;
            axi.arvalid <= 1'b0;
            axi.araddr  <= '0;
            axi.rready  <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            rsp_valid_o <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    cmd_ready_o <= 1'b1;
                    if (cmd_valid_i && cmd_ready_o) begin
                        cmd_ready_o <= 1'b0;
                        if (cmd_we_i) begin
                            axi.awaddr  <= cmd_addr_i;
                            axi.wdata   <= cmd_wdata_i;
                            axi.wstrb   <= cmd_wstrb_i;
                            axi.awvalid <= 1'b1;
                            axi.wvalid  <= 1'b1;
                            aw_done_q   <= 1'b0;
                            w_done_q    <= 1'b0;
                            state_q     <= S_WADDR;
                        end else begin
                            axi.araddr  <= cmd_addr_i;
                            axi.arvalid <= 1'b1;
                            state_q     <= S_RADDR;
                        end
                    end
                end
                S_WADDR: begin
                    if (aw_hs) begin
                        axi.awvalid <= 1'b0;
                        aw_done_q   <= 1'b1;
                    end
                    if (w_hs) begin
                        axi.wvalid <= 1'b0;
                        w_done_q   <= 1'b1;
                    end
                    if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                        axi.bready <= 1'b1;
                        state_q    <= S_WRESP;
`ifdef AXI_MASTER_TIMEOUT_EN
                        to_cnt_q   <= '0;
`endif
                    end
                end
                S_WRESP: begin
                    if (axi.bvalid) begin
                        axi.bready  <= 1'b0;
                        rsp_resp_o  <= axi.bresp;
                        rsp_rdata_o <= '0;
                        rsp_valid_o <= 1'b1;
                        state_q     <= S_DONE;
                    end
`ifdef AXI_MASTER_TIMEOUT_EN
                    else if (to_cnt_q == TO_LAST) begin
                        axi.bready  <= 1'b0;
                        rsp_resp_o  <= 2'b11;
                        rsp_rdata_o <= '0;
                        rsp_valid_o <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end
                S_RADDR: begin
                    if (axi.arready) begin
                        axi.arvalid <= 1'b0;
                        axi.rready  <= 1'b1;
                        state_q     <= S_RDATA;
`ifdef AXI_MASTER_TIMEOUT_EN
                        to_cnt_q    <= '0;
`endif
                    end
                end
                S_RDATA: begin
                    if (axi.rvalid) begin
                        axi.rready  <= 1'b0;
                        rsp_resp_o  <= axi.rresp;
                        rsp_rdata_o <= axi.rdata;
                        rsp_valid_o <= 1'b1;
                        state_q     <= S_DONE;
                    end
`ifdef AXI_MASTER_TIMEOUT_EN
                    else if (to_cnt_q == TO_LAST) begin
                        axi.rready  <= 1'b0;
                        rsp_resp_o  <= 2'b11;
                        rsp_rdata_o <= '0;
                        rsp_valid_o <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    cmd_ready_o <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// tb_axi_lite_master_ctrl: scoreboard bench with a behavioural AXI-Lite slave.
// Define AXI_MASTER_TIMEOUT_EN to build the timeout variant (TIMEOUT_CYCLES=8).
module tb_axi_lite_master_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 256;
`endif

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready_o;
    logic          cmd_we = 1'b0;
    logic [31:0]   cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid_o;
    logic [31:0]   rsp_rdata_o;
    logic [1:0]    rsp_resp_o;

    axi_lite_master_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

    axi_lite_master_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we),
        .cmd_addr_i  (cmd_addr),
        .cmd_wdata_i (cmd_wdata),
        .cmd_wstrb_i (cmd_wstrb),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_resp_o  (rsp_resp_o),
        .axi         (axi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int failures = 0;

    int cyc = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0;
    int aw_cyc = 0, w_cyc = 0, aw_rise = 0, w_unstable = 0, rsp_cnt = 0;
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr, wdata_prev, tmp;
    logic [3:0]  cap_wstrb;
    logic        awvalid_prev = 1'b0, wvalid_prev = 1'b0;

    // Bus monitor: records handshakes on pre-edge values.
    always @(posedge clk) begin
        cyc++;
        aw_hs = axi.awvalid && axi.awready;
        w_hs  = axi.wvalid && axi.wready;
        b_hs  = axi.bvalid && axi.bready;
        ar_hs = axi.arvalid && axi.arready;
        r_hs  = axi.rvalid && axi.rready;
        if (aw_hs) begin aw_cnt++; aw_cyc = cyc; cap_awaddr = axi.awaddr; end
        if (w_hs) begin
            w_cnt++; w_cyc = cyc;
            cap_wdata = axi.wdata; cap_wstrb = axi.wstrb;
        end
        if (b_hs) b_cnt++;
        if (ar_hs) begin ar_cnt++; cap_araddr = axi.araddr; end
        if (axi.wvalid && wvalid_prev && axi.wdata !== wdata_prev) w_unstable++;
        if (axi.awvalid && !awvalid_prev) aw_rise++;
        awvalid_prev = axi.awvalid;
        wvalid_prev  = axi.wvalid;
        wdata_prev   = axi.wdata;
        if (rsp_valid_o) rsp_cnt++;
    end

    bit no_b = 0, no_r = 0, w_delay = 0;
    bit s_aw_got, s_w_got;
    int s_wait;
    logic [31:0] mem [logic [31:0]];

    // Slave model: registered responses, optional wready delay / missing responses.
    always @(negedge clk) begin
        if (!rst_ni) begin
            axi.awready = 1'b1; axi.wready = 1'b1; axi.arready = 1'b1;
            axi.bvalid = 1'b0; axi.rvalid = 1'b0;
            axi.bresp = 2'b00; axi.rresp = 2'b00; axi.rdata = '0;
            s_aw_got = 0; s_w_got = 0; s_wait = 0;
        end else begin
            if (b_hs) axi.bvalid = 1'b0;
            if (r_hs) axi.rvalid = 1'b0;
            if (aw_hs) s_aw_got = 1;
            if (w_hs) s_w_got = 1;
            if (s_aw_got && s_w_got) begin
                s_aw_got = 0; s_w_got = 0; s_wait = 0;
                if (cap_awaddr[31]) begin
                    axi.bresp = 2'b10;
                end else begin
                    tmp = mem.exists(cap_awaddr) ? mem[cap_awaddr] : 32'h0;
                    for (int i = 0; i < 4; i++)
                        if (cap_wstrb[i]) tmp[8*i +: 8] = cap_wdata[8*i +: 8];
                    mem[cap_awaddr] = tmp;
                    axi.bresp = 2'b00;
                end
                if (!no_b) axi.bvalid = 1'b1;
            end
            if (ar_hs && !no_r) begin
                if (cap_araddr[31]) begin
                    axi.rdata = '0; axi.rresp = 2'b10;
                end else begin
                    axi.rdata = mem.exists(cap_araddr) ? mem[cap_araddr] : 32'h0;
                    axi.rresp = 2'b00;
                end
                axi.rvalid = 1'b1;
            end
            if (w_delay) begin
                if (s_aw_got && !s_w_got) s_wait++;
                axi.wready = s_aw_got && !s_w_got && (s_wait >= 4);
            end else begin
                axi.wready = 1'b1;
            end
        end
    end

    // Drive one command from a negedge; returns at the negedge after acceptance.
    task automatic send_cmd(input bit we, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb,
                            output bit ok);
        ok = 0;
        cmd_we = we; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready_o) begin
                @(posedge clk);
                @(negedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    // Wait for rsp_valid; lat counts cycles from the acceptance cycle.
    task automatic wait_rsp(input int budget, output bit got, output int lat);
        got = 0; lat = 1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid_o) begin got = 1; break; end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (cmd_ready_o !== 1'b0) begin
            failures++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready_o);
        end
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid_o);
        end
        checks++;
        if ({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready} !== 5'b0) begin
            failures++;
            $display("FAIL rst_bus_valids got=%b exp=00000",
                     {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready});
        end
        checks++;
        if ({rsp_rdata_o, rsp_resp_o} !== 34'h0) begin
            failures++; $display("FAIL rst_rsp_data got=%h/%b exp=0/00", rsp_rdata_o, rsp_resp_o);
        end
        checks++;
        if ({axi.awaddr, axi.araddr, axi.wdata} !== 96'h0) begin
            failures++; $display("FAIL rst_bus_addr got=%h/%h/%h exp=0", axi.awaddr, axi.araddr, axi.wdata);
        end
        #2 rst_ni = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            failures++; $display("FAIL rst_release_ready got=%b exp=1", cmd_ready_o);
        end
    endtask

    task automatic test_write();
        bit ok, got; int lat; int aw0; exp_t e;
        aw0 = aw_cnt;
        sb_q.push_back('{rdata: 32'h0, resp: 2'b00});
        send_cmd(1'b1, 32'h0000_100A, 32'h0000_00FF, 4'hF, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL wr_accept got=0 exp=1"); end
        wait_rsp(20, got, lat);
        checks++;
        if (!got || lat !== 3) begin
            failures++; $display("FAIL wr_latency got=%0d (seen=%0d) exp=3", lat, got);
        end
        checks++;
        if (aw_cyc !== w_cyc || aw_cnt - aw0 !== 1) begin
            failures++; $display("FAIL wr_same_cycle got aw=%0d w=%0d exp equal", aw_cyc, w_cyc);
        end
        e = sb_q.pop_front();
        checks++;
        if (rsp_resp_o !== e.resp || rsp_rdata_o !== e.rdata) begin
            failures++;
            $display("FAIL wr_rsp got=%h/%b exp=%h/%b", rsp_rdata_o, rsp_resp_o, e.rdata, e.resp);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL wr_pulse got rsp=%b rdy=%b exp rsp=0 rdy=1", rsp_valid_o, cmd_ready_o);
        end
    endtask

    task automatic test_read();
        bit ok, got; int lat; exp_t e;
        sb_q.push_back('{rdata: 32'h0000_00FF, resp: 2'b00});
        send_cmd(1'b0, 32'h0000_100A, 32'h0, 4'h0, ok);
        wait_rsp(20, got, lat);
        checks++;
        if (!ok || !got || lat !== 3) begin
            failures++; $display("FAIL rd_latency got=%0d (seen=%0d) exp=3", lat, got);
        end
        checks++;
        if (cap_araddr !== 32'h0000_100A) begin
            failures++; $display("FAIL rd_araddr got=%h exp=0000100a", cap_araddr);
        end
        e = sb_q.pop_front();
        checks++;
        if (rsp_rdata_o !== e.rdata || rsp_resp_o !== e.resp) begin
            failures++;
            $display("FAIL rd_rsp got=%h/%b exp=%h/%b", rsp_rdata_o, rsp_resp_o, e.rdata, e.resp);
        end
        @(negedge clk);
        checks++;
        if (rsp_rdata_o !== e.rdata) begin
            failures++; $display("FAIL rd_hold got=%h exp=%h", rsp_rdata_o, e.rdata);
        end
    endtask

    task automatic test_slverr();
        bit ok, got; int lat; exp_t e;
        sb_q.push_back('{rdata: 32'h0, resp: 2'b10});
        send_cmd(1'b1, 32'h8000_100A, 32'h0000_0055, 4'hF, ok);
        wait_rsp(20, got, lat);
        e = sb_q.pop_front();
        checks++;
        if (!got || rsp_resp_o !== e.resp || rsp_rdata_o !== e.rdata) begin
            failures++; $display("FAIL slverr_wr got=%h/%b exp=%h/%b", rsp_rdata_o, rsp_resp_o, e.rdata, e.resp);
        end
        @(negedge clk);
        sb_q.push_back('{rdata: 32'h0000_00FF, resp: 2'b00});
        send_cmd(1'b0, 32'h0000_100A, 32'h0, 4'h0, ok);
        wait_rsp(20, got, lat);
        e = sb_q.pop_front();
        checks++;
        if (!got || rsp_rdata_o !== e.rdata || rsp_resp_o !== e.resp) begin
            failures++; $display("FAIL slverr_rdback got=%h/%b exp=%h/%b", rsp_rdata_o, rsp_resp_o, e.rdata, e.resp);
        end
        @(negedge clk);
    endtask

    task automatic test_wready_delay();
        bit ok, got; int lat; int aw0, b0, r0; exp_t e;
        aw0 = aw_cnt; b0 = b_cnt; r0 = aw_rise; w_unstable = 0;
        w_delay = 1;
        sb_q.push_back('{rdata: 32'h0, resp: 2'b00});
        send_cmd(1'b1, 32'h0000_1010, 32'h0000_00AA, 4'h1, ok);
        wait_rsp(30, got, lat);
        e = sb_q.pop_front();
        checks++;
        if (!got || rsp_resp_o !== e.resp) begin
            failures++; $display("FAIL dly_rsp got=%b (seen=%0d) exp=%b", rsp_resp_o, got, e.resp);
        end
        checks++;
        if (w_cyc - aw_cyc !== 4) begin
            failures++; $display("FAIL dly_gap got=%0d exp=4", w_cyc - aw_cyc);
        end
        checks++;
        if (aw_cnt - aw0 !== 1 || aw_rise - r0 !== 1) begin
            failures++;
            $display("FAIL dly_aw_once got hs=%0d rise=%0d exp 1/1", aw_cnt - aw0, aw_rise - r0);
        end
        checks++;
        if (w_unstable !== 0 || cap_wdata !== 32'h0000_00AA) begin
            failures++; $display("FAIL dly_wdata got=%h unstable=%0d exp=000000aa", cap_wdata, w_unstable);
        end
        checks++;
        if (b_cnt - b0 !== 1) begin
            failures++; $display("FAIL dly_bhs got=%0d exp=1", b_cnt - b0);
        end
        w_delay = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        bit ok; int r0;
        no_b = 1;
        r0 = rsp_cnt;
        send_cmd(1'b1, 32'h0000_1020, 32'h1234_5678, 4'hF, ok);
        @(negedge clk);
        checks++;
        if (axi.bready !== 1'b1) begin
            failures++; $display("FAIL mid_bready got=%b exp=1", axi.bready);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({axi.bready, rsp_valid_o, cmd_ready_o} !== 3'b000) begin
            failures++;
            $display("FAIL mid_async got=%b%b%b exp=000", axi.bready, rsp_valid_o, cmd_ready_o);
        end
        @(negedge clk);
        no_b = 0;
        #2 rst_ni = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready_o !== 1'b1 || rsp_cnt !== r0) begin
            failures++;
            $display("FAIL mid_recover got rdy=%b rsp=%0d exp rdy=1 rsp=%0d", cmd_ready_o, rsp_cnt, r0);
        end
    endtask

`ifdef AXI_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        bit ok, got; int lat; exp_t e;
        no_r = 1;
        sb_q.push_back('{rdata: 32'h0, resp: 2'b11});
        send_cmd(1'b0, 32'h0000_100A, 32'h0, 4'h0, ok);
        wait_rsp(30, got, lat);
        e = sb_q.pop_front();
        checks++;
        if (!got || lat !== 10) begin
            failures++; $display("FAIL to_latency got=%0d (seen=%0d) exp=10", lat, got);
        end
        checks++;
        if (rsp_resp_o !== e.resp || rsp_rdata_o !== e.rdata) begin
            failures++; $display("FAIL to_rsp got=%h/%b exp=%h/%b", rsp_rdata_o, rsp_resp_o, e.rdata, e.resp);
        end
        @(negedge clk);
        checks++;
        if (axi.rready !== 1'b0 || cmd_ready_o !== 1'b1) begin
            failures++; $display("FAIL to_idle got rready=%b rdy=%b exp 0/1", axi.rready, cmd_ready_o);
        end
        no_r = 0;
    endtask
`else
    task automatic test_no_timeout();
        bit ok, got; int lat;
        no_r = 1;
        send_cmd(1'b0, 32'h0000_100A, 32'h0, 4'h0, ok);
        wait_rsp(40, got, lat);
        checks++;
        if (got || axi.rready !== 1'b1) begin
            failures++; $display("FAIL nto_wait got seen=%0d rready=%b exp 0/1", got, axi.rready);
        end
        #2 rst_ni = 1'b0;
        @(negedge clk);
        no_r = 0;
        #2 rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_ready_o !== 1'b1 || axi.rready !== 1'b0) begin
            failures++; $display("FAIL nto_recover got rdy=%b rready=%b exp 1/0", cmd_ready_o, axi.rready);
        end
    endtask
`endif

    initial begin
        axi.awready = 1'b1; axi.wready = 1'b1; axi.arready = 1'b1;
        axi.bvalid = 1'b0; axi.rvalid = 1'b0;
        axi.bresp = 2'b00; axi.rresp = 2'b00; axi.rdata = '0;
        test_reset();
        test_write();
        test_read();
        test_slverr();
        test_wready_delay();
        test_reset_mid_write();
`ifdef AXI_MASTER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        checks++;
        if (sb_q.size() !== 0) begin
            failures++; $display("FAIL sb_empty got=%0d exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
